// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: imem request/response channel, branch redirect and the downstream instruction channel.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited imem requests, response FIFO with PCs, redirect flush with stale-response discard.
// Latency: accept at t, response at t+1, instr_valid at t+2; issue stalls when outstanding+discard+count reaches DEPTH.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 10,
  parameter int                DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           clk_en,
  instr_fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_disc;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

  logic [SW-1:0] w_inflight;
  logic          w_credit;
  logic          w_redir;
  logic          w_accept;
  logic          w_keep;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  assign w_inflight = SW'(r_outst) + SW'(r_disc) + SW'(r_count);
  assign w_credit   = w_inflight < SW'(DEPTH);
  assign w_redir    = clk_en & bus.redirect_valid;

  assign bus.imem_req_valid = ~rst & clk_en & ~bus.redirect_valid & w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign w_accept           = bus.imem_req_valid & bus.imem_req_ready;

  // Memory cannot be stalled, so responses are consumed regardless of clk_en.
  assign w_drop = bus.imem_rsp_valid & (r_disc != '0);
  assign w_keep = bus.imem_rsp_valid & (r_disc == '0);
  assign w_push = w_keep & ~w_redir;

  assign bus.instr_valid = clk_en & (r_count != '0);
  assign bus.instr_data  = r_mem_data[r_rptr];
  assign bus.instr_pc    = r_mem_pc[r_rptr];
  assign w_pop           = bus.instr_valid & bus.instr_ready & ~w_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_disc     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (w_redir) begin
      r_fetch_pc <= bus.redirect_pc;
      r_rsp_pc   <= bus.redirect_pc;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_outst    <= '0;
      // Whatever response lands this cycle retires one in-flight slot, kept or dropped.
      r_disc     <= r_disc + r_outst - CW'(bus.imem_rsp_valid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + ADDR_W'(1);
        r_wptr   <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_accept) - CW'(w_keep);
      r_disc  <= r_disc - CW'(w_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == CW'(DEPTH))));
  a_budget:      assert property (@(posedge clk) disable iff (rst) (w_inflight <= SW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order imem model with hold control, expected PCs queued per scenario and checked on pop.
module tb_instr_fetch;
  logic clk;
  logic rst;
  logic clk_en;
  bit   mem_hold;
  int   n_checks;
  int   n_fail;

  logic [15:0] mem_q  [$];
  logic [15:0] exp_pc [$];

  instr_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'd10), .DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  // Memory: records acceptances, returns words in order no earlier than the following edge.
  always @(posedge clk) begin
    if (rst) mem_q.delete();
    else if (bus.imem_req_valid && bus.imem_req_ready) mem_q.push_back(bus.imem_req_addr);
    #2;
    if (rst || mem_hold || mem_q.size() == 0) begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q.pop_front());
    end
  end

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b1; mem_hold = 1'b0;
    bus.imem_req_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1;
    exp_pc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; mem_hold = 1'b0;
    bus.imem_req_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_checks++; if (bus.imem_req_addr !== 16'd10) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 000a", bus.imem_req_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
    n_checks++; if (bus.instr_data !== 32'h0) begin n_fail++; $display("FAIL reset_instr_data: got %h expected 0", bus.instr_data); end
    n_checks++; if (bus.instr_pc !== 16'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
  endtask

  task automatic test_stream();
    int nacc = 0;
    int first_acc = -1;
    int first_vld = -1;
    logic [15:0] pc;
    do_reset();
    for (int i = 0; i < 6; i++) exp_pc.push_back(16'(10 + i));
    for (int cyc = 0; cyc < 60 && exp_pc.size() != 0; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (first_acc < 0) first_acc = cyc;
        if (nacc < 6) begin
          n_checks++;
          if (bus.imem_req_addr !== 16'(10 + nacc)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", nacc, bus.imem_req_addr, 16'(10 + nacc)); end
        end
        nacc++;
      end
      if (bus.instr_valid && first_vld < 0) first_vld = cyc;
      if (bus.instr_valid && bus.instr_ready) begin
        pc = exp_pc.pop_front();
        n_checks++;
        if (bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL stream_pop: got pc %h data %h expected pc %h data %h", bus.instr_pc, bus.instr_data, pc, mem_word(pc)); end
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_pc.size() != 0) begin n_fail++; $display("FAIL stream_timeout: %0d instructions still expected, expected 0", exp_pc.size()); end
    n_checks++; if (first_vld - first_acc != 2) begin n_fail++; $display("FAIL stream_latency: got %0d cycles expected 2", first_vld - first_acc); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    logic [15:0] pc;
    do_reset();
    bus.instr_ready = 1'b0;
    exp_pc.push_back(16'd10);
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_checks++;
        if (bus.imem_req_addr !== 16'(10 + nacc)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", nacc, bus.imem_req_addr, 16'(10 + nacc)); end
        nacc++;
      end
      @(negedge clk); #1;
    end
    n_checks++; if (nacc != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 2", nacc); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %b expected 0", bus.imem_req_valid); end
    @(negedge clk);
    bus.instr_ready = 1'b1;
    #1;
    pc = exp_pc.pop_front();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL bp_head: got valid %b pc %h data %h expected 1 %h %h", bus.instr_valid, bus.instr_pc, bus.instr_data, pc, mem_word(pc)); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'd12) begin n_fail++; $display("FAIL bp_resume: got valid %b addr %h expected 1 000c", bus.imem_req_valid, bus.imem_req_addr); end
    n_checks++; if (bus.instr_pc !== 16'd11) begin n_fail++; $display("FAIL bp_next_head: got %h expected 000b", bus.instr_pc); end
  endtask

  task automatic test_redirect_inflight();
    int nacc = 0;
    int first_addr = -1;
    logic [15:0] pc;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd20; mem_hold = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_checks++;
        if (bus.imem_req_addr !== 16'(20 + nacc)) begin n_fail++; $display("FAIL rdi_addr[%0d]: got %h expected %h", nacc, bus.imem_req_addr, 16'(20 + nacc)); end
        nacc++;
      end
      @(negedge clk); #1;
    end
    n_checks++; if (nacc != 2) begin n_fail++; $display("FAIL rdi_inflight: got %0d expected 2", nacc); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_mask: got %b expected 0", bus.imem_req_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0; mem_hold = 1'b0;
    exp_pc.push_back(16'h0100); exp_pc.push_back(16'h0101);
    #1;
    for (int cyc = 0; cyc < 40 && exp_pc.size() != 0; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready && first_addr < 0) first_addr = int'(bus.imem_req_addr);
      if (bus.instr_valid && bus.instr_ready) begin
        pc = exp_pc.pop_front();
        n_checks++;
        if (bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL rdi_pop: got pc %h data %h expected pc %h", bus.instr_pc, bus.instr_data, pc); end
      end
      @(negedge clk); #1;
    end
    n_checks++; if (first_addr != 16'h0100) begin n_fail++; $display("FAIL rdi_first_addr: got %0h expected 100", first_addr); end
    n_checks++; if (exp_pc.size() != 0) begin n_fail++; $display("FAIL rdi_timeout: %0d still expected, expected 0", exp_pc.size()); end
  endtask

  task automatic test_redirect_collide();
    int nacc = 0;
    logic [15:0] pc;
    do_reset();
    mem_hold = 1'b1; bus.instr_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) nacc++;
      @(negedge clk); #1;
    end
    n_checks++; if (nacc != 2) begin n_fail++; $display("FAIL rdc_inflight: got %0d expected 2", nacc); end
    mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    bus.instr_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0200;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd10 || bus.imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rdc_setup: got valid %b pc %h rsp %b expected 1 000a 1", bus.instr_valid, bus.instr_pc, bus.imem_rsp_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    exp_pc.push_back(16'h0200); exp_pc.push_back(16'h0201);
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_flush: got %b expected 0", bus.instr_valid); end
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0200) begin n_fail++; $display("FAIL rdc_reissue: got valid %b addr %h expected 1 0200", bus.imem_req_valid, bus.imem_req_addr); end
    for (int cyc = 0; cyc < 40 && exp_pc.size() != 0; cyc++) begin
      if (bus.instr_valid && bus.instr_ready) begin
        pc = exp_pc.pop_front();
        n_checks++;
        if (bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL rdc_pop: got pc %h data %h expected pc %h", bus.instr_pc, bus.instr_data, pc); end
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_pc.size() != 0) begin n_fail++; $display("FAIL rdc_timeout: %0d still expected, expected 0", exp_pc.size()); end
  endtask

  task automatic test_wrap();
    int nacc = 0;
    logic [15:0] base = 16'hFFFE;
    logic [15:0] pc;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = base;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) exp_pc.push_back(base + 16'(i));
    #1;
    for (int cyc = 0; cyc < 40 && exp_pc.size() != 0; cyc++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (nacc < 3) begin
          n_checks++;
          if (bus.imem_req_addr !== base + 16'(nacc)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", nacc, bus.imem_req_addr, base + 16'(nacc)); end
        end
        nacc++;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        pc = exp_pc.pop_front();
        n_checks++;
        if (bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL wrap_pop: got pc %h data %h expected pc %h", bus.instr_pc, bus.instr_data, pc); end
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_pc.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: %0d still expected, expected 0", exp_pc.size()); end
  endtask

  task automatic test_clk_en();
    logic [15:0] pc;
    do_reset();
    mem_hold = 1'b1;
    exp_pc.push_back(16'd10);
    @(negedge clk);
    clk_en = 1'b0; mem_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ce_req_valid[%0d]: got %b expected 0", i, bus.imem_req_valid); end
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL ce_instr_valid[%0d]: got %b expected 0", i, bus.instr_valid); end
      @(negedge clk);
    end
    clk_en = 1'b1;
    #1;
    pc = exp_pc.pop_front();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== pc || bus.instr_data !== mem_word(pc)) begin n_fail++; $display("FAIL ce_capture: got valid %b pc %h data %h expected 1 %h %h", bus.instr_valid, bus.instr_pc, bus.instr_data, pc, mem_word(pc)); end
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'd11) begin n_fail++; $display("FAIL ce_resume: got valid %b addr %h expected 1 000b", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_clk_en();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
